taxi_axis_frame_arb_rr: RTL
===========================

TAXI_AXIS_FRAME_ARB_RR -- requirements
Module: taxi_axis_frame_arb_rr

Interface
REQ-001 Parameter PORTS, default 2: number of requesting AXI4-Stream sources, range 2..8.
REQ-002 Parameter DATA_W, default 64: tdata width.
REQ-003 Parameter KEEP_W, default DATA_W/8: tkeep width.
REQ-004 Parameter ID_W, default 8: tid width.
REQ-005 Parameter USER_W, default 1: tuser width; bit 0 is the bad-frame flag.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1: sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1: asynchronous assert, active-low reset.
REQ-009 enable  input  1: when high, new frames may be granted.
REQ-010 s_tdata/s_tkeep/s_tid/s_tuser  input  PORTS*DATA_W / PORTS*KEEP_W / PORTS*ID_W / PORTS*USER_W: per-port payload, port n in slice n.
REQ-011 s_tvalid, s_tlast  input  PORTS: per-port valid and end of frame.
REQ-012 s_tready  output  PORTS: per-port ready.
REQ-013 m_tdata, m_tkeep, m_tid, m_tuser, m_tvalid, m_tlast  output  DATA_W, KEEP_W, ID_W, USER_W, 1, 1: merged stream to the MAC transmit path.
REQ-014 m_tready  input  1: downstream ready.
REQ-015 grant_valid  output  1: high while a frame is in progress.
REQ-016 grant_idx  output  $clog2(PORTS): index of the currently or last granted port.
REQ-017 frame_cnt  output  32: count of frames completed on m.

Function
REQ-018 The block SHALL have two states, IDLE and BUSY.
REQ-019 In IDLE: s_tready all 0 and m_tvalid 0.
REQ-020 IDLE -> BUSY when enable=1 and any s_tvalid=1. Select the first port with s_tvalid=1, scanning (grant_idx+1) mod PORTS upward with wrap. Load grant_idx. Set grant_valid=1.
REQ-021 In BUSY, with g=grant_idx, the datapath is combinational:
  - m_* equals s_*[g]
  - m_tvalid equals s_tvalid[g]
  - s_tready[g] equals m_tready
  - every other s_tready is 0
REQ-022 A beat transfers on m_tvalid && m_tready. Transfer with m_tlast=1 -> IDLE, grant_valid=0, frame_cnt += 1.
REQ-023 Arbitration latency: first beat of a granted frame SHALL transfer no earlier than the cycle after s_tvalid is first sampled in IDLE.
REQ-024 Exactly one idle (no-transfer) cycle SHALL separate consecutive frames.
REQ-025 A grant is frame-granular. Deasserting enable, or asserting s_tvalid on other ports, SHALL NOT preempt a frame in BUSY.
REQ-026 enable=0 in IDLE: no grant. s_tvalid on any port is held off indefinitely.
REQ-027 Fairness: with all PORTS requesting continuously, grants SHALL rotate 0,1,...,PORTS-1,0,...
REQ-028 A port never waits more than PORTS-1 other frames.
REQ-029 A single-beat frame (s_tlast on first beat) SHALL complete BUSY in one transfer cycle.
REQ-030 frame_cnt SHALL wrap from 0xFFFFFFFF to 0 without saturation.
REQ-031 tuser is passed through unmodified. The block does not drop bad frames.
REQ-032 A source deasserting s_tvalid mid-frame SHALL hold BUSY and the grant until its s_tlast transfers. There is no timeout.

Reset
REQ-033 While rst_n=0: state=IDLE, grant_valid=0, grant_idx=PORTS-1 (port 0 wins first), frame_cnt=0, all s_tready=0, m_tvalid=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately. No further beats transfer, and m_tlast is not synthesised.
REQ-035 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge at which rst_n is sampled high.

Verification
REQ-036 Ports 0 and 1 each present a 3-beat frame in the same cycle after reset, m_tready=1 -> port 0 frame out (beats 1-3), 1 idle cycle, port 1 frame out; frame_cnt=2; grant_idx=1.
REQ-037 All 4 ports (PORTS=4) request continuously with 1-beat frames for 8 frames -> grant_idx sequence 0,1,2,3,0,1,2,3; frame_cnt=8.
REQ-038 Port 1 granted with a 4-beat frame; m_tready toggles 1,0,1,0,...; port 0 requests mid-frame -> port 1 beats in order with none lost; s_tready[0]=0 until port 1 tlast; port 0 granted next.
REQ-039 enable=0 with port 0 valid for 10 cycles -> no transfer; enable=1 -> port 0 granted next cycle. enable dropped during BUSY -> frame completes.
REQ-040 Reset pulsed low during beat 2 of a 5-beat frame -> all outputs at reset values asynchronously; frame_cnt=0; next grant goes to port 0.
REQ-041 frame_cnt preloaded (via force) to 0xFFFFFFFF, one frame completes -> frame_cnt=0.

Source files
------------

// File: rtl/taxi_axis_frame_arb_rr.sv
// ============================================================================
// taxi_axis_frame_arb_rr
//
// Frame-granular round-robin arbiter that merges PORTS AXI4-Stream sources
// onto a single stream toward the MAC transmit path. A grant is made only
// between frames and is held until the granted source's tlast beat transfers.
//
// Handshake: a beat moves on any interface in the cycle where tvalid and
// tready are both high at the rising clock edge. The m-side valid is the
// granted source's valid. The granted source's ready is the downstream ready.
// Neither ready depends on its own valid. All other sources see ready low.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          allows new grants (never preempts a frame in flight)
//   s_tdata/tkeep/tid/tuser   per-port payload, port n in slice n
//   s_tvalid/tlast  per-port valid and end-of-frame
//   s_tready        per-port ready
//   m_tdata/tkeep/tid/tuser/tvalid/tlast, m_tready   merged output stream
//   grant_valid     high while a frame is in progress (exposes the FSM state)
//   grant_idx       port currently granted, or last granted
//   frame_cnt       frames completed on m, wraps at 2^32
// ============================================================================
module taxi_axis_frame_arb_rr #(
    parameter int PORTS  = 2,
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PORTS*DATA_W-1:0]       s_tdata,
    input  logic [PORTS*KEEP_W-1:0]       s_tkeep,
    input  logic [PORTS*ID_W-1:0]         s_tid,
    input  logic [PORTS*USER_W-1:0]       s_tuser,
    input  logic [PORTS-1:0]              s_tvalid,
    input  logic [PORTS-1:0]              s_tlast,
    output logic [PORTS-1:0]              s_tready,
    output logic [DATA_W-1:0]             m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic [ID_W-1:0]               m_tid,
    output logic [USER_W-1:0]             m_tuser,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic                          grant_valid,
    output logic [$clog2(PORTS)-1:0]      grant_idx,
    output logic [31:0]                   frame_cnt
);

    localparam int IDX_W = $clog2(PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  grant_next;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic              busy;
    logic              last_xfer;

    assign busy        = (state == BUSY);
    assign grant_valid = busy;

    // Round-robin pick: scan from the port after the last grant, wrapping,
    // so the most recently served port has the lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_idx;
        cand      = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = IDX_W'((int'(grant_idx) + i) % PORTS);
            if (!sel_found && s_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Combinational datapath: payload follows grant_idx at all times, while
    // valid/ready are only opened for the granted port while BUSY.
    always_comb begin
        m_tdata  = s_tdata[int'(grant_idx)*DATA_W +: DATA_W];
        m_tkeep  = s_tkeep[int'(grant_idx)*KEEP_W +: KEEP_W];
        m_tid    = s_tid[int'(grant_idx)*ID_W +: ID_W];
        m_tuser  = s_tuser[int'(grant_idx)*USER_W +: USER_W];
        m_tlast  = s_tlast[grant_idx];
        m_tvalid = busy & s_tvalid[grant_idx];
        s_tready = '0;
        if (busy) begin
            s_tready[grant_idx] = m_tready;
        end
    end

    assign last_xfer = m_tvalid & m_tready & m_tlast;

    always_comb begin
        state_next = state;
        grant_next = grant_idx;
        case (state)
            IDLE: begin
                if (enable && sel_found) begin
                    state_next = BUSY;
                    grant_next = sel_idx;
                end
            end
            BUSY: begin
                // Leaving BUSY forces one IDLE cycle between frames.
                if (last_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // grant_idx resets to the last port so port 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= IDX_W'(PORTS - 1);
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_next;
            if (last_xfer) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

endmodule
